// File: rtl/radix4_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock into a 2N-bit accumulator.
// Define RADIX4_APPROX_EN to replace the low M bits of the 2X multiple with the matching bits of X.
module radix4_booth_seq_mult #(
  parameter int N = 16,
  parameter int M = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sgn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2*N-1:0] p
);
  localparam int W  = N + 2;
  localparam int CW = $clog2(N/2 + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [W-1:0]   xr;
  logic [W:0]     yr;      // {y_ext, y[-1]}; shifts right two bits per digit
  logic [CW-1:0]  cnt, klast;
  logic [2*N-1:0] acc;
  logic           last;
  logic [W-1:0]   x2, mag, pp;
  logic           neg;
  logic [2*N-1:0] ppx;

  assign last = (cnt == klast);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

`ifdef RADIX4_APPROX_EN
  always_comb begin
    x2 = {xr[W-2:0], 1'b0};
    for (int b = 0; b < W; b++)
      if (b < M) x2[b] = xr[b];
  end
`else
  assign x2 = {xr[W-2:0], 1'b0};
`endif

  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (yr[2:0])
      3'b001, 3'b010: mag = xr;
      3'b011:         mag = x2;
      3'b100:         begin mag = x2; neg = 1'b1; end
      3'b101, 3'b110: begin mag = xr; neg = 1'b1; end
      default:        mag = '0;
    endcase
  end

  assign pp  = neg ? -mag : mag;
  assign ppx = {{(2*N-W){pp[W-1]}}, pp};

  always_ff @(posedge clk) begin
    if (rst) begin
      xr    <= '0;
      yr    <= '0;
      cnt   <= '0;
      klast <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          xr    <= sgn ? {{2{x[N-1]}}, x} : {2'b00, x};
          yr    <= {(sgn ? {{2{y[N-1]}}, y} : {2'b00, y}), 1'b0};
          cnt   <= '0;
          klast <= sgn ? CW'(N/2 - 1) : CW'(N/2);
          acc   <= '0;
        end
        RUN: begin
          acc <= acc + (ppx << {cnt, 1'b0});
          yr  <= yr >> 2;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign p = acc;
endmodule

// File: tb/tb_radix4_booth_seq_mult.sv
// Scoreboard bench for radix4_booth_seq_mult: exact DUT (M=0) plus a second instance with M=16.
module tb_radix4_booth_seq_mult;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_valid_ap = 1'b0, sgn = 1'b0, out_ready = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        in_ready, out_valid, in_ready_ap, out_valid_ap;
  logic [31:0] p, p_ap;

  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0;
  bit acc_sgn = 1'b0, prev_ov = 1'b0, auto_rdy = 1'b0;
  logic [31:0] exp_q[$], exp_ap[$];

  radix4_booth_seq_mult #(.N(16), .M(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready), .p(p));

  radix4_booth_seq_mult #(.N(16), .M(16)) dut_ap (
    .clk(clk), .rst(rst), .in_valid(in_valid_ap), .in_ready(in_ready_ap), .x(x), .y(y), .sgn(sgn),
    .out_valid(out_valid_ap), .out_ready(out_ready), .p(p_ap));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // monitor: latency tracking and scoreboard pops
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      acc_cyc = cyc + 1;
      acc_sgn = sgn;
    end
    if (out_valid && !prev_ov) chk("latency", 32'(cyc - acc_cyc), acc_sgn ? 32'd8 : 32'd9);
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got %h, expected no output", p);
      end else chk("product", p, exp_q.pop_front());
    end
    if (out_valid_ap && out_ready) begin
      if (exp_ap.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output_ap: got %h, expected no output", p_ap);
      end else chk("product_ap", p_ap, exp_ap.pop_front());
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input int gap,
                       input bit ap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    x = a; y = b; sgn = s;
    if (ap) in_valid_ap = 1'b1; else in_valid = 1'b1;
    while (!(ap ? in_ready_ap : in_ready)) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
        $fatal(1, "accept timeout");
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_ap = 1'b0;
    x = 16'($urandom); y = 16'($urandom); sgn = 1'($urandom);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [31:0] e, input int gap);
    exp_q.push_back(e);
    issue(a, b, s, gap, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_ap.size() != 0 || !in_ready) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size() + exp_ap.size());
    end
  endtask

  typedef struct { logic [15:0] a; logic [15:0] b; logic s; logic [31:0] e; } vec_t;
  vec_t vecs[$];

  initial begin
    vecs = '{
      '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001},
      '{16'hFFFF, 16'h8000, 1'b1, 32'h00008000},
      '{16'h8000, 16'h8000, 1'b0, 32'h40000000},
      '{16'h8000, 16'h8000, 1'b1, 32'h40000000},
      '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000},
      '{16'h0000, 16'h1234, 1'b0, 32'h00000000},
      '{16'h1234, 16'h0010, 1'b0, 32'h00012340},
      '{16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA},
      '{16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF},
      '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001}
    };

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", p, 32'd0);
    rst = 1'b0;
    auto_rdy = 1'b1;

    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, i % 2);
    drain();

    // back-pressure: hold the product for 20 cycles, then a one-cycle out_ready pulse
    auto_rdy = 1'b0; out_ready = 1'b0;
    send(16'h1234, 16'h0010, 1'b0, 32'h00012340, 0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    end
    for (int k = 0; k < 20; k++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_p", p, 32'h00012340);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    auto_rdy = 1'b1;

    // reset during the 4th RUN cycle discards the operation
    issue(16'd5, 16'd7, 1'b0, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_p", p, 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    send(16'd5, 16'd7, 1'b0, 32'd35, 0);
    drain();

    // rst and in_valid together: operands not captured
    x = 16'd9; y = 16'd9; sgn = 1'b0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    chk("rst_vs_valid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_vs_valid_p", p, 32'd0);

    // low-order approximation of the 2X multiple (M=16)
`ifdef RADIX4_APPROX_EN
    exp_ap.push_back(32'd9);
`else
    exp_ap.push_back(32'd6);
`endif
    issue(16'd3, 16'd2, 1'b0, 0, 1'b1);
    exp_ap.push_back(32'd3);
    issue(16'd3, 16'd1, 1'b0, 0, 1'b1);
    drain();

    // randomised exact sweep
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a, b;
      logic s;
      logic [31:0] e;
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      if (s) e = 32'($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b}));
      else   e = {16'h0, a} * {16'h0, b};
      send(a, b, s, e, $urandom_range(0, 2));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
